// File: rtl/prio_enc_led_if.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_led_if
//  Description : Switch-bank / LED-bank signal bundle for prio_enc_led.
//                master = stimulus side (drives switches, hold, mode),
//                slave  = encoder side (drives code, flags and LED image).
//  Ports       : sw[N-1:0], hold, pri_hi  (master -> slave)
//                code[W-1:0], valid, multi, chg, ledr[15:0] (slave -> master)
//  Revision    : 1.0  initial release
// ============================================================================
interface prio_enc_led_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic [N-1:0]  sw;
    logic          hold;
    logic          pri_hi;
    logic [W-1:0]  code;
    logic          valid;
    logic          multi;
    logic          chg;
    logic [15:0]   ledr;

    modport master (
        output sw, hold, pri_hi,
        input  code, valid, multi, chg, ledr
    );

    modport slave (
        input  sw, hold, pri_hi,
        output code, valid, multi, chg, ledr
    );
endinterface
`default_nettype wire

// File: rtl/prio_enc_led.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc_led
//  Description : Debounced, registered priority encoder for the board switch
//                bank. Switches are synchronised and debounced as a whole
//                vector, priority-encoded (highest or lowest index wins) and
//                registered together with valid / multi-active / change
//                flags. A hold button freezes the registered outputs.
//  Ports       : clk          system clock, rising edge
//                rst          asynchronous active-low reset
//                bus.sw       raw switches (async)
//                bus.hold     raw hold button (async, high = freeze)
//                bus.pri_hi   quasi-static priority direction (1 = highest)
//                bus.code     winning channel index
//                bus.valid    at least one debounced channel set
//                bus.multi    two or more debounced channels set
//                bus.chg      one-cycle pulse on any change of the outputs
//                bus.ledr     LED image {valid, multi, hold, 5'b0, code}
//  Revision    : 1.0  initial release
// ============================================================================
module prio_enc_led #(
    parameter int N         = 8,
    parameter int DB_CYCLES = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    prio_enc_led_if.slave  bus
);
    localparam int W       = $clog2(N);
    localparam int c_CNT_W = $clog2(DB_CYCLES) + 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DB_CYCLES - 1);

    // synchronisers
    logic [N-1:0]        r_s1;
    logic [N-1:0]        r_s2;
    logic                r_h1;
    logic                r_h2;

    // debounce state
    logic [N-1:0]        r_cand;
    logic [N-1:0]        r_deb;
    logic [c_CNT_W-1:0]  r_cnt;

    // output register
    logic [W-1:0]        r_code;
    logic                r_valid;
    logic                r_multi;
    logic                r_chg;

    // encoder results
    logic [W-1:0]        w_code;
    logic                w_valid;
    logic                w_multi;
    logic [15:0]         w_ledr;

    // ------------------------------------------------------------------
    // Two-flop synchronisers for the switch vector and the hold button
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_h1 <= 1'b0;
            r_h2 <= 1'b0;
        end else begin
            r_s1 <= bus.sw;
            r_s2 <= r_s1;
            r_h1 <= bus.hold;
            r_h2 <= r_h1;
        end
    end

    // ------------------------------------------------------------------
    // Vector debounce: a candidate is accepted only after it has been seen
    // unchanged for DB_CYCLES further cycles. Any movement of the
    // synchronised vector replaces the candidate and restarts the count.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cand <= '0;
            r_deb  <= '0;
            r_cnt  <= '0;
        end else if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= '0;
        end else if (r_cand != r_deb) begin
            if (r_cnt == c_CNT_LAST) begin
                r_deb <= r_cand;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else begin
            r_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Priority encoder. The scan direction is chosen so that the last
    // match in loop order is the winner for the selected mode.
    // ------------------------------------------------------------------
    always_comb begin
        w_code = '0;
        if (bus.pri_hi) begin
            for (int i = 0; i < N; i++) begin
                if (r_deb[i]) begin
                    w_code = W'(i);
                end
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (r_deb[i]) begin
                    w_code = W'(i);
                end
            end
        end
    end

    assign w_valid = |r_deb;
    // clearing the lowest set bit leaves something only if two or more were set
    assign w_multi = |(r_deb & (r_deb - N'(1)));

    // ------------------------------------------------------------------
    // Output register with freeze. chg is forced low while frozen, so a
    // change that happened during hold is reported on release instead.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code  <= '0;
            r_valid <= 1'b0;
            r_multi <= 1'b0;
            r_chg   <= 1'b0;
        end else if (!r_h2) begin
            r_code  <= w_code;
            r_valid <= w_valid;
            r_multi <= w_multi;
            r_chg   <= ({w_code, w_valid, w_multi} != {r_code, r_valid, r_multi});
        end else begin
            r_chg   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // LED image
    // ------------------------------------------------------------------
    always_comb begin
        w_ledr          = '0;
        w_ledr[15]      = r_valid;
        w_ledr[14]      = r_multi;
        w_ledr[13]      = r_h2;
        w_ledr[W-1:0]   = r_code;
    end

    assign bus.code  = r_code;
    assign bus.valid = r_valid;
    assign bus.multi = r_multi;
    assign bus.chg   = r_chg;
    assign bus.ledr  = w_ledr;

endmodule
`default_nettype wire

// File: tb/tb_prio_enc_led.sv
`default_nettype none
// ============================================================================
//  Module      : tb_prio_enc_led
//  Description : Self-checking bench for prio_enc_led (N=8, DB_CYCLES=4).
//                A behavioural model tracks how long the synchronised switch
//                vector has been stable and encodes with plain arithmetic.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_prio_enc_led;
    localparam int N  = 8;
    localparam int DB = 4;
    localparam int W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    prio_enc_led_if #(.N(N)) bus ();

    prio_enc_led #(.N(N), .DB_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [N-1:0] m_q1, m_q2, m_deb, m_last;
    int           m_run;
    logic         m_hq1, m_hq2;
    logic [W-1:0] m_code;
    logic         m_valid, m_multi, m_chg;

    // index of the highest (hi=1) or lowest (hi=0) set bit, 0 for none
    function automatic int winner(input logic [N-1:0] v, input logic hi);
        int x;
        int idx;
        x   = int'(v);
        idx = 0;
        if (!hi) x = x & -x;
        while (x > 1) begin
            x = x >> 1;
            idx++;
        end
        return idx;
    endfunction

    // a vector is accepted once DB+1 consecutive samples of it were seen
    function automatic int next_run();
        return (m_q2 == m_last) ? ((m_run < 1000) ? m_run + 1 : m_run) : 1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q1 <= '0; m_q2 <= '0; m_deb <= '0; m_last <= '0; m_run <= 0;
            m_hq1 <= 1'b0; m_hq2 <= 1'b0;
            m_code <= '0; m_valid <= 1'b0; m_multi <= 1'b0; m_chg <= 1'b0;
        end else begin
            if (!m_hq2) begin
                m_code  <= W'(winner(m_deb, bus.pri_hi));
                m_valid <= (m_deb != '0);
                m_multi <= ($countones(m_deb) > 1);
                m_chg   <= ({W'(winner(m_deb, bus.pri_hi)), (m_deb != '0), ($countones(m_deb) > 1)}
                            != {m_code, m_valid, m_multi});
            end else begin
                m_chg <= 1'b0;
            end
            m_run  <= next_run();
            m_last <= m_q2;
            if (next_run() >= DB + 1) m_deb <= m_q2;
            m_q2  <= m_q1;
            m_q1  <= bus.sw;
            m_hq2 <= m_hq1;
            m_hq1 <= bus.hold;
        end
    end

    function automatic logic [21:0] obs();
        return {bus.code, bus.valid, bus.multi, bus.chg, bus.ledr};
    endfunction

    function automatic logic [21:0] expv();
        return {m_code, m_valid, m_multi, m_chg, m_valid, m_multi, m_hq2, 10'b0, m_code};
    endfunction

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        bus.sw = 8'hFF; bus.hold = 1'b0; bus.pri_hi = 1'b1;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 22'd0) begin
            n_fail++; $display("FAIL reset_immediate: got %h want %h", obs(), 22'd0);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (obs() !== 22'd0) begin
            n_fail++; $display("FAIL reset_held: got %h want %h", obs(), 22'd0);
        end
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL reset_model k=%0d: got %h want %h", k, obs(), expv());
            end
            if (k == 6) begin
                n_checks++;
                if (bus.valid !== 1'b0) begin
                    n_fail++; $display("FAIL reset_early: valid got %b want 0", bus.valid);
                end
            end
            if (k == 7) begin
                n_checks++;
                if (obs() !== {3'd7, 1'b1, 1'b1, 1'b1, 16'hC007}) begin
                    n_fail++; $display("FAIL reset_latency: got %h want %h", obs(), {3'd7, 3'b111, 16'hC007});
                end
            end
            if (k == 8) begin
                n_checks++;
                if (bus.chg !== 1'b0) begin
                    n_fail++; $display("FAIL reset_chg_once: chg got %b want 0", bus.chg);
                end
            end
        end
    endtask

    task automatic test_single();
        bus.sw = 8'h00;
        repeat (12) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL single_settle: got %h want %h", obs(), expv());
            end
        end
        bus.sw = 8'b0000_0100;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL single_model k=%0d: got %h want %h", k, obs(), expv());
            end
            if (k == 7) begin
                n_checks++;
                if (obs() !== {3'd2, 1'b1, 1'b0, 1'b1, 16'h8002}) begin
                    n_fail++; $display("FAIL single_latency: got %h want %h", obs(), {3'd2, 3'b101, 16'h8002});
                end
            end
            if (k > 7) begin
                n_checks++;
                if (bus.chg !== 1'b0) begin
                    n_fail++; $display("FAIL single_no_chg k=%0d: chg got %b want 0", k, bus.chg);
                end
            end
        end
    endtask

    task automatic test_priority();
        bus.sw = 8'b1001_0010;
        repeat (10) @(negedge clk);
        n_checks++;
        if ({bus.code, bus.valid, bus.multi, bus.ledr} !== {3'd7, 1'b1, 1'b1, 16'hC007}) begin
            n_fail++; $display("FAIL prio_hi: got code=%0d ledr=%h want code=7 ledr=c007", bus.code, bus.ledr);
        end
        bus.pri_hi = 1'b0;
        @(negedge clk);
        n_checks++;
        if (obs() !== {3'd1, 1'b1, 1'b1, 1'b1, 16'hC001}) begin
            n_fail++; $display("FAIL prio_lo: got %h want %h", obs(), {3'd1, 3'b111, 16'hC001});
        end
        @(negedge clk);
        n_checks++;
        if ({bus.code, bus.chg} !== {3'd1, 1'b0}) begin
            n_fail++; $display("FAIL prio_lo_pulse: got code=%0d chg=%b want code=1 chg=0", bus.code, bus.chg);
        end
        bus.pri_hi = 1'b1;
        @(negedge clk);
        n_checks++;
        if (obs() !== expv()) begin
            n_fail++; $display("FAIL prio_back: got %h want %h", obs(), expv());
        end
    endtask

    task automatic test_glitch();
        logic [21:0] snap;
        @(negedge clk);
        snap = obs();
        bus.sw = 8'b1011_0010;
        repeat (3) @(negedge clk);
        bus.sw = 8'b1001_0010;
        repeat (10) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== snap || obs() !== expv()) begin
                n_fail++; $display("FAIL glitch_short: got %h want %h", obs(), snap);
            end
        end
        for (int i = 0; i < 12; i++) begin
            bus.sw = (i % 2 == 0) ? 8'b1001_0011 : 8'b1001_0010;
            repeat (2) begin
                @(negedge clk);
                n_checks++;
                if (obs() !== snap) begin
                    n_fail++; $display("FAIL glitch_toggle i=%0d: got %h want %h", i, obs(), snap);
                end
            end
        end
        bus.sw = 8'b1001_0010;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_hold();
        bus.sw = 8'h04;
        repeat (10) @(negedge clk);
        n_checks++;
        if (obs() !== {3'd2, 1'b1, 1'b0, 1'b0, 16'h8002}) begin
            n_fail++; $display("FAIL hold_pre: got %h want %h", obs(), {3'd2, 3'b100, 16'h8002});
        end
        bus.hold = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.ledr[13] !== 1'b0) begin
            n_fail++; $display("FAIL hold_sync1: ledr13 got %b want 0", bus.ledr[13]);
        end
        @(negedge clk);
        n_checks++;
        if (bus.ledr !== 16'hA002) begin
            n_fail++; $display("FAIL hold_sync2: ledr got %h want a002", bus.ledr);
        end
        bus.sw = 8'h40;
        repeat (12) begin
            @(negedge clk);
            n_checks++;
            if ({bus.code, bus.valid, bus.chg} !== {3'd2, 1'b1, 1'b0} || obs() !== expv()) begin
                n_fail++; $display("FAIL hold_frozen: got %h want code=2 chg=0 (%h)", obs(), expv());
            end
        end
        bus.hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus.code, bus.chg, bus.ledr[13]} !== {3'd2, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL hold_h2_fall: got code=%0d chg=%b h=%b want 2,0,0", bus.code, bus.chg, bus.ledr[13]);
        end
        @(negedge clk);
        n_checks++;
        if (obs() !== {3'd6, 1'b1, 1'b0, 1'b1, 16'h8006}) begin
            n_fail++; $display("FAIL hold_release: got %h want %h", obs(), {3'd6, 3'b101, 16'h8006});
        end
        @(negedge clk);
        n_checks++;
        if ({bus.code, bus.chg} !== {3'd6, 1'b0}) begin
            n_fail++; $display("FAIL hold_release_pulse: got code=%0d chg=%b want 6,0", bus.code, bus.chg);
        end
    endtask

    task automatic test_reset_mid();
        bus.sw = 8'h81;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 22'd0) begin
            n_fail++; $display("FAIL rstmid_immediate: got %h want %h", obs(), 22'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (obs() !== expv()) begin
                n_fail++; $display("FAIL rstmid_model k=%0d: got %h want %h", k, obs(), expv());
            end
            if (k == 6) begin
                n_checks++;
                if (bus.valid !== 1'b0) begin
                    n_fail++; $display("FAIL rstmid_early: valid got %b want 0", bus.valid);
                end
            end
            if (k == 7) begin
                n_checks++;
                if (obs() !== {3'd7, 1'b1, 1'b1, 1'b1, 16'hC007}) begin
                    n_fail++; $display("FAIL rstmid_latency: got %h want %h", obs(), {3'd7, 3'b111, 16'hC007});
                end
            end
        end
    endtask

    task automatic test_random();
        int len;
        for (int i = 0; i < 80; i++) begin
            bus.sw = ($urandom_range(0, 3) == 0) ? N'(1 << $urandom_range(0, N - 1)) : N'($urandom);
            if ($urandom_range(0, 3) == 0) bus.pri_hi = ~bus.pri_hi;
            if ($urandom_range(0, 5) == 0) bus.hold = ~bus.hold;
            len = $urandom_range(1, 10);
            repeat (len) begin
                @(negedge clk);
                n_checks++;
                if (obs() !== expv()) begin
                    n_fail++; $display("FAIL random i=%0d sw=%h: got %h want %h", i, bus.sw, obs(), expv());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_glitch();
        test_hold();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prio_enc_led.md
# prio_enc_led

Parametrised, debounced, registered priority encoder for the board switch bank. It is the successor of the fixed 4-to-2 switch encoder.
- N switch channels are synchronised and debounced as a vector, then priority-encoded with a selectable direction.
- Results are registered, with valid, multiple-active and change flags.
- Outputs can be frozen by a hold button.
- It drives the LED bank directly and feeds the code to downstream display logic.

## Interface
- N, 8: number of switch channels; power of two, 2..256.
- W, $clog2(N): code width; derived, not overridden.
- DB_CYCLES, 4: stable cycles required before a new switch vector is accepted; ≥1.
- clk  in  1  system clock; all flops on rising edge.
- rst  in  1  reset, asynchronous, active-low; asserting low clears all state immediately; release is synchronous to clk.
- sw  in  N  raw switch inputs, asynchronous to clk.
- hold  in  1  raw hold button (high = freeze outputs), asynchronous to clk.
- pri_hi  in  1  quasi-static mode: 1 = highest set index wins, 0 = lowest set index wins; not synchronised.
- code  out  W  encoded index of the winning channel.
- valid  out  1  at least one debounced channel set.
- multi  out  1  more than one debounced channel set.
- chg  out  1  one-cycle pulse when {valid, multi, code} changes.
- ledr  out  16  LED image.
  - ledr[15] = valid, ledr[14] = multi, ledr[13] = synchronised hold.
  - ledr[7:0] = code zero-extended; for N=256 code fills [7:0].
  - All other bits 0.

## Operation
- Synchroniser:
  - sw goes through two flops (s1, s2), each N bits.
  - hold goes through its own two flops (h1, h2); hold is not debounced.
- Debounce, as one vector with registers cand[N-1:0], deb[N-1:0] and cnt (width $clog2(DB_CYCLES)+1), evaluated in priority order:
  - s2 != cand: cand <= s2, cnt <= 0.
  - else cand != deb and cnt == DB_CYCLES-1: deb <= cand, cnt <= 0.
  - else cand != deb: cnt <= cnt+1.
  - else: cnt <= 0.
  - Any change of s2 restarts the count. A glitch shorter than the stable window never reaches deb.
- Encoder (combinational on deb and pri_hi):
  - nxt_valid = |deb.
  - nxt_multi = deb has two or more bits set.
  - nxt_code = index of the highest set bit (pri_hi=1) or the lowest set bit (pri_hi=0).
  - deb == 0: nxt_code = 0, nxt_valid = 0, nxt_multi = 0.
- Output register, updated every cycle while h2 = 0:
  - {code, valid, multi} <= {nxt_code, nxt_valid, nxt_multi}.
  - chg <= 1 iff the new triple differs from the current triple, else 0.
- Hold:
  - While h2 = 1, code, valid and multi keep their values and chg = 0.
  - Debounce continues to run during hold.
  - On the first cycle with h2 = 0 the output register loads the current encoder result; chg pulses if it differs from the frozen value.
- pri_hi change: affects the encoder immediately. Outputs reflect it at the next edge (if not held), with chg if the result differs.
- ledr is combinational from the output register and h2.

## Timing
- Reset (rst low):
  - s1, s2, h1, h2, cand, deb and cnt = 0.
  - code = 0, valid = 0, multi = 0, chg = 0, ledr = 16'h0000.
  - All take effect without a clock edge.
- Latency:
  - Let E0 be the first edge at which s1 captures a new sw value, with sw stable afterwards.
  - s2 updates at E0+1, cand at E0+2, deb at E0+2+DB_CYCLES.
  - code/valid/multi/chg update at E0+3+DB_CYCLES. This is edge E0+7 for DB_CYCLES=4.
- Hold latency: h2 follows hold 2 edges after capture. Freeze and release take effect at the edge after h2 changes.
- chg is high for exactly one cycle per output change. Back-to-back changes on consecutive cycles give back-to-back pulses.
- Reset asserted mid-debounce discards cand/cnt progress. After release the full latency applies from the first sampling edge.
- Throughput: one accepted vector per DB_CYCLES+1 cycles minimum; intermediate unstable values are dropped.

## Test plan
Bench configuration: N=8, DB_CYCLES=4, pri_hi=1 unless stated.
- Reset:
  - Stimulus: rst low with sw=8'hFF.
  - Required: all outputs 0 and ledr=16'h0000 immediately.
  - After release, at E0+7: code=7, valid=1, multi=1, ledr=16'hC007, chg pulses once.
- Single switch:
  - Stimulus: from sw=0, set sw=8'b0000_0100.
  - Required: at E0+7 code=2, valid=1, multi=0, ledr=16'h8002, chg=1 for one cycle; no chg afterwards.
- Priority mode:
  - Stimulus: sw=8'b1001_0010.
  - Required: code=7, multi=1, ledr=16'hC007.
  - Then pri_hi→0: code=1, ledr=16'hC001 at the next edge, with one chg pulse.
- Glitch rejection:
  - Stimulus: sw bit 5 high for 3 cycles, then back.
  - Required: deb, outputs and chg unchanged.
  - Also: sw toggling every 2 cycles must never update the outputs.
- Hold:
  - Stimulus: hold=1 (ledr[13]=1 after 2 edges), then sw 8'h04→8'h40.
  - Required: code stays 2 and chg=0.
  - Release hold: code=6 one edge after h2 falls, single chg pulse.
- Reset mid-debounce:
  - Stimulus: sw change, then rst low for half a cycle at E0+4.
  - Required: outputs 0 at once.
  - After release, outputs update at the full latency measured from the new E0.
